// File: rtl/fp_mul_pkg.sv
// Shared definitions for the pipelined floating-point multiplier:
// operand classes, rounding-mode encodings and format helper functions.
package fp_mul_pkg;

    localparam logic RND_RNE   = 1'b0;
    localparam logic RND_TRUNC = 1'b1;

    typedef enum logic [1:0] {
        ZERO,
        NORM,
        INF,
        NAN
    } fp_class_e;

    function automatic int exp_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    // Quiet NaN with sign 0, all-ones exponent and only the mantissa MSB set.
    function automatic logic [63:0] canon_nan(input int exp_w, input int man_w);
        return (((64'd1 << exp_w) - 64'd1) << man_w) | (64'd1 << (man_w - 1));
    endfunction

endpackage

// File: rtl/fp_mul_round.sv
// Stage-3 combinational logic: normalise the mantissa product, round,
// detect overflow/underflow and pack the final result with its flags.
module fp_mul_round
    import fp_mul_pkg::*;
#(
    parameter  int EXP_W = 5,
    parameter  int MAN_W = 10,
    localparam int W     = 1 + EXP_W + MAN_W,
    localparam int XW    = EXP_W + 2,
    localparam int PW    = 2 * MAN_W + 2
) (
    input  logic                 sign_i,
    input  fp_class_e            cls_i,
    input  logic                 rnd_i,
    input  logic signed [XW-1:0] exp_i,
    input  logic [PW-1:0]        prod_i,
    output logic [W-1:0]         data_o,
    output logic [2:0]           flags_o
);

    localparam logic signed [XW-1:0] ONE     = XW'(1);
    localparam logic signed [XW-1:0] EXP_MAX = XW'((1 << EXP_W) - 1);
    localparam logic [W-1:0]         QNAN    = W'(canon_nan(EXP_W, MAN_W));

    logic [PW-2:0]        frac;
    logic signed [XW-1:0] exp_n;
    logic signed [XW-1:0] exp_f;
    logic [MAN_W:0]       man_r;
    logic                 round_up;
    logic [W-1:0]         inf_val;
    logic [W-1:0]         zero_val;

    always_comb begin
        // Product is in [1,4): drop the hidden one, realigning when it sits one place lower.
        frac     = prod_i[PW-1] ? prod_i[PW-2:0] : {prod_i[PW-3:0], 1'b0};
        exp_n    = prod_i[PW-1] ? exp_i + ONE : exp_i;
        round_up = (rnd_i == RND_RNE) && frac[MAN_W] &&
                   ((|frac[MAN_W-1:0]) || frac[MAN_W+1]);
        man_r    = {1'b0, frac[PW-2:MAN_W+1]} + (MAN_W+1)'(round_up);
        exp_f    = man_r[MAN_W] ? exp_n + ONE : exp_n;
        inf_val  = {sign_i, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        zero_val = {sign_i, {(W-1){1'b0}}};

        data_o  = zero_val;
        flags_o = 3'b000;
        case (cls_i)
            NAN: begin
                data_o  = QNAN;
                flags_o = 3'b100;
            end
            INF:  data_o = inf_val;
            ZERO: data_o = zero_val;
            default: begin
                if (exp_f >= EXP_MAX) begin
                    data_o  = inf_val;
                    flags_o = 3'b010;
                end else if (exp_f < ONE) begin
                    data_o  = zero_val;
                    flags_o = 3'b001;
                end else begin
                    // A rounding carry leaves man_r low bits at zero, as required.
                    data_o = {sign_i, exp_f[EXP_W-1:0], man_r[MAN_W-1:0]};
                end
            end
        endcase
    end

endmodule

// File: rtl/fp_mul_pipe.sv
// Three-stage IEEE-style floating-point multiplier with valid/ready flow
// control: S1 unpack/classify, S2 mantissa product, S3 round/pack.
module fp_mul_pipe
    import fp_mul_pkg::*;
#(
    parameter  int EXP_W = 5,
    parameter  int MAN_W = 10,
    localparam int W     = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] data1,
    input  logic [W-1:0] data2,
    input  logic         input_valid,
    output logic         input_ready,
    input  logic         rnd_mode,
    output logic [W-1:0] datanew,
    output logic         output_update,
    input  logic         output_ready,
    output logic [2:0]   flags
);

    localparam int            XW   = EXP_W + 2;
    localparam int            PW   = 2 * MAN_W + 2;
    localparam logic [XW-1:0] BIAS = XW'(exp_bias(EXP_W));

    typedef struct packed {
        logic          sign;
        fp_class_e     cls;
        logic          rnd;
        logic [XW-1:0] exp;
        logic [MAN_W:0] man_a;
        logic [MAN_W:0] man_b;
    } s1_t;

    typedef struct packed {
        logic          sign;
        fp_class_e     cls;
        logic          rnd;
        logic [XW-1:0] exp;
        logic [PW-1:0] prod;
    } s2_t;

    function automatic fp_class_e classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] m);
        if (e == '1) begin
            if (m == '0) return INF;
            return NAN;
        end
        if (e == '0) return ZERO;  // subnormals are flushed to zero
        return NORM;
    endfunction

    s1_t       s1_d, s1_q;
    s2_t       s2_d, s2_q;
    fp_class_e cls_a, cls_b;
    logic      s1_valid_q, s2_valid_q, out_valid_q;
    logic      advance;
    logic [W-1:0] datanew_q, round_data;
    logic [2:0]   flags_q, round_flags;

    assign advance     = !(out_valid_q && !output_ready);
    assign input_ready = advance;

    always_comb begin
        cls_a      = classify(data1[W-2:MAN_W], data1[MAN_W-1:0]);
        cls_b      = classify(data2[W-2:MAN_W], data2[MAN_W-1:0]);
        s1_d.sign  = data1[W-1] ^ data2[W-1];
        s1_d.rnd   = rnd_mode;
        s1_d.exp   = {2'b00, data1[W-2:MAN_W]} + {2'b00, data2[W-2:MAN_W]} - BIAS;
        s1_d.man_a = {1'b1, data1[MAN_W-1:0]};
        s1_d.man_b = {1'b1, data2[MAN_W-1:0]};
        if (cls_a == NAN || cls_b == NAN || (cls_a == INF && cls_b == ZERO) ||
            (cls_a == ZERO && cls_b == INF))
            s1_d.cls = NAN;
        else if (cls_a == INF || cls_b == INF)
            s1_d.cls = INF;
        else if (cls_a == ZERO || cls_b == ZERO)
            s1_d.cls = ZERO;
        else
            s1_d.cls = NORM;
    end

    always_comb begin
        s2_d.sign = s1_q.sign;
        s2_d.cls  = s1_q.cls;
        s2_d.rnd  = s1_q.rnd;
        s2_d.exp  = s1_q.exp;
        s2_d.prod = PW'(s1_q.man_a) * PW'(s1_q.man_b);
    end

    fp_mul_round #(
        .EXP_W(EXP_W),
        .MAN_W(MAN_W)
    ) u_round (
        .sign_i (s2_q.sign),
        .cls_i  (s2_q.cls),
        .rnd_i  (s2_q.rnd),
        .exp_i  (s2_q.exp),
        .prod_i (s2_q.prod),
        .data_o (round_data),
        .flags_o(round_flags)
    );

    // NOTE: only valids and the visible outputs are reset; the payload
    // registers below are always qualified by a valid and need no reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s2_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            datanew_q   <= '0;
            flags_q     <= '0;
        end else if (advance) begin
            s1_valid_q  <= input_valid;
            s2_valid_q  <= s1_valid_q;
            out_valid_q <= s2_valid_q;
            if (s2_valid_q) begin
                datanew_q <= round_data;
                flags_q   <= round_flags;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (advance) begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign datanew       = datanew_q;
    assign flags         = flags_q;
    assign output_update = out_valid_q;

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Scoreboard bench for fp_mul_pipe: directed and random binary16 traffic
// under random back-pressure, reset flush, plus a binary32 instance.
module tb_fp_mul_pipe;

    localparam int EW = 5;
    localparam int MW = 10;
    localparam int W  = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [W-1:0]  data1 = '0, data2 = '0, datanew;
    logic          input_valid = 1'b0, input_ready, rnd_mode = 1'b0;
    logic          output_update, output_ready = 1'b1;
    logic [2:0]    flags;

    logic [31:0]   a32 = '0, b32 = '0, d32;
    logic          iv32 = 1'b0, ir32, rnd32 = 1'b0, ou32;
    logic [2:0]    flags32;

    int checks = 0, errors = 0, outs_seen = 0;

    typedef struct {
        logic [W-1:0] d;
        logic [2:0]   f;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        bit          r;
        logic [15:0] d;
        logic [2:0]  f;
    } vec_t;

    fp_mul_pipe #(.EXP_W(EW), .MAN_W(MW)) dut (
        .clk(clk), .rst(rst), .data1(data1), .data2(data2),
        .input_valid(input_valid), .input_ready(input_ready), .rnd_mode(rnd_mode),
        .datanew(datanew), .output_update(output_update),
        .output_ready(output_ready), .flags(flags)
    );

    fp_mul_pipe #(.EXP_W(8), .MAN_W(23)) dut32 (
        .clk(clk), .rst(rst), .data1(a32), .data2(b32),
        .input_valid(iv32), .input_ready(ir32), .rnd_mode(rnd32),
        .datanew(d32), .output_update(ou32),
        .output_ready(1'b1), .flags(flags32)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    // Reference product from exact integer arithmetic: significand product,
    // remainder-based rounding, then range checks on the true exponent.
    function automatic void ref_mul(input logic [63:0] a, input logic [63:0] b, input bit trunc,
                                    input int ew, input int mw,
                                    output logic [63:0] res, output logic [2:0] fl);
        longint unsigned emax, mmask, ma, mb, p, q, r, half, sgn, qnan, infv;
        longint ea, eb, e, bias;
        int sh;
        bit nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
        emax   = (64'd1 << ew) - 1;
        mmask  = (64'd1 << mw) - 1;
        ea     = longint'((a >> mw) & emax);
        eb     = longint'((b >> mw) & emax);
        ma     = a & mmask;
        mb     = b & mmask;
        sgn    = (((a >> (ew + mw)) ^ (b >> (ew + mw))) & 64'd1) << (ew + mw);
        qnan   = (emax << mw) | (64'd1 << (mw - 1));
        infv   = sgn | (emax << mw);
        nan_a  = (ea == longint'(emax)) && (ma != 0);
        nan_b  = (eb == longint'(emax)) && (mb != 0);
        inf_a  = (ea == longint'(emax)) && (ma == 0);
        inf_b  = (eb == longint'(emax)) && (mb == 0);
        zero_a = (ea == 0);
        zero_b = (eb == 0);
        fl     = 3'b000;
        if (nan_a || nan_b || (inf_a && zero_b) || (zero_a && inf_b)) begin
            res = qnan;
            fl  = 3'b100;
        end else if (inf_a || inf_b) begin
            res = infv;
        end else if (zero_a || zero_b) begin
            res = sgn;
        end else begin
            bias = (longint'(1) << (ew - 1)) - 1;
            p    = (ma | (64'd1 << mw)) * (mb | (64'd1 << mw));
            e    = ea + eb - bias;
            sh   = mw;
            if (p >= (64'd1 << (2 * mw + 1))) begin
                sh = mw + 1;
                e++;
            end
            q    = p >> sh;
            r    = p & ((64'd1 << sh) - 1);
            half = 64'd1 << (sh - 1);
            if (!trunc && (r > half || (r == half && q[0]))) q++;
            if (q == (64'd1 << (mw + 1))) begin
                q = q >> 1;
                e++;
            end
            if (e >= longint'(emax)) begin
                res = infv;
                fl  = 3'b010;
            end else if (e <= 0) begin
                res = sgn;
                fl  = 3'b001;
            end else begin
                res = sgn | (64'(e) << mw) | (q & mmask);
            end
        end
    endfunction

    function automatic logic [15:0] rand_h();
        logic       s;
        logic [4:0] e;
        logic [9:0] m;
        s = 1'($urandom_range(0, 1));
        m = 10'($urandom);
        case ($urandom_range(0, 15))
            0: begin e = 5'd0;  m = '0; end
            1: begin e = 5'd0;  m = m | 10'd1; end
            2: begin e = 5'd31; m = '0; end
            3: begin e = 5'd31; m = m | 10'd1; end
            4: e = 5'($urandom_range(24, 30));
            5: e = 5'($urandom_range(1, 6));
            default: e = 5'($urandom_range(1, 30));
        endcase
        return {s, e, m};
    endfunction

    // Monitor: handshake rule, hold-while-stalled and in-order scoreboard.
    initial begin
        bit          stalled_prev = 1'b0;
        logic [18:0] prev_out = '0;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (rst) begin
                stalled_prev = 1'b0;
            end else begin
                check("input_ready_rule", input_ready, !(output_update && !output_ready));
                if (stalled_prev) begin
                    check("hold_valid", output_update, 1'b1);
                    check("hold_value", {flags, datanew}, prev_out);
                end
                if (output_update) outs_seen++;
                if (output_update && output_ready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_result: got %0h with empty scoreboard", datanew);
                    end else begin
                        e = sb.pop_front();
                        check("result_data", datanew, e.d);
                        check("result_flags", flags, e.f);
                    end
                end
                stalled_prev = output_update && !output_ready;
                prev_out     = {flags, datanew};
            end
        end
    end

    task automatic step(input bit v, input logic [W-1:0] a, input logic [W-1:0] b, input bit r,
                        input bit ordy, input logic [W-1:0] wd, input logic [2:0] wf,
                        output bit acc);
        input_valid  = v;
        data1        = a;
        data2        = b;
        rnd_mode     = r;
        output_ready = ordy;
        @(negedge clk);
        acc = v && input_ready;
        if (acc) sb.push_back('{wd, wf});
        @(posedge clk);
        #1;
    endtask

    task automatic send_model(input logic [15:0] a, input logic [15:0] b, input bit r,
                              input int ready_pct);
        bit          acc = 1'b0;
        logic [63:0] res;
        logic [2:0]  fl;
        ref_mul(64'(a), 64'(b), r, EW, MW, res, fl);
        for (int t = 0; t < 64 && !acc; t++)
            step(1'b1, a, b, r, $urandom_range(0, 99) < ready_pct, res[15:0], fl, acc);
        check("accept_within_bound", acc, 1'b1);
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, 1'b1, '0, '0, acc);
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && sb.size() != 0; i++) idle(1);
        check("drain_empty", sb.size(), 0);
    endtask

    task automatic measure_latency(input string name);
        int lat = 0;
        bit seen = 1'b0;
        input_valid = 1'b0;
        while (lat < 10 && !seen) begin
            @(negedge clk);
            lat++;
            seen = output_update;
        end
        check(name, lat, 3);
        @(posedge clk);
        #1;
    endtask

    task automatic fp32_op(input logic [31:0] a, input logic [31:0] b, input bit r,
                           input logic [31:0] wd, input logic [2:0] wf, input string name);
        int n = 0;
        iv32  = 1'b1;
        a32   = a;
        b32   = b;
        rnd32 = r;
        @(posedge clk);
        #1;
        iv32 = 1'b0;
        while (n < 10 && !ou32) begin
            @(negedge clk);
            n++;
        end
        check(name, {ou32, flags32, d32}, {1'b1, wf, wd});
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[9] = '{
        '{16'h5BF0, 16'h47AF, 1'b0, 16'h67A0, 3'b000},
        '{16'h5BF0, 16'h47AF, 1'b1, 16'h679F, 3'b000},
        '{16'h4440, 16'h4660, 1'b0, 16'h4EC6, 3'b000},
        '{16'hC000, 16'h4000, 1'b0, 16'hC400, 3'b000},
        '{16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, 3'b010},
        '{16'h0400, 16'h0400, 1'b0, 16'h0000, 3'b001},
        '{16'h0000, 16'h7C00, 1'b0, 16'h7E00, 3'b100},
        '{16'h7E01, 16'h3C00, 1'b0, 16'h7E00, 3'b100},
        '{16'h8000, 16'h4000, 1'b0, 16'h8000, 3'b000}
    };

    initial begin
        bit          acc;
        int          outs_before;
        logic [63:0] res;
        logic [2:0]  fl;
        logic [31:0] ra, rb;

        repeat (2) @(negedge clk);
        check("reset_update", output_update, 1'b0);
        check("reset_data", datanew, 16'h0000);
        check("reset_flags", flags, 3'b000);
        check("reset_ready", input_ready, 1'b1);
        check("reset_update32", ou32, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        step(1'b1, vecs[0].a, vecs[0].b, vecs[0].r, 1'b1, vecs[0].d, vecs[0].f, acc);
        check("first_accept", acc, 1'b1);
        measure_latency("latency_first");

        for (int i = 1; i < 9; i++) begin
            step(1'b1, vecs[i].a, vecs[i].b, vecs[i].r, 1'b1, vecs[i].d, vecs[i].f, acc);
            check("burst_accept", acc, 1'b1);
        end
        drain();

        for (int i = 0; i < 8; i++) send_model(rand_h(), rand_h(), 1'b0, 50);
        drain();

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            send_model(rand_h(), rand_h(), 1'($urandom_range(0, 1)), 70);
        end
        drain();

        step(1'b1, 16'h4000, 16'h4000, 1'b0, 1'b1, 16'h4400, 3'b000, acc);
        step(1'b1, 16'h4200, 16'h4000, 1'b0, 1'b1, 16'h4600, 3'b000, acc);
        input_valid = 1'b0;
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        check("midrst_update", output_update, 1'b0);
        check("midrst_data", datanew, 16'h0000);
        check("midrst_ready", input_ready, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        outs_before = outs_seen;
        idle(6);
        check("flushed_no_output", outs_seen - outs_before, 0);
        step(1'b1, vecs[3].a, vecs[3].b, vecs[3].r, 1'b1, vecs[3].d, vecs[3].f, acc);
        check("post_reset_accept", acc, 1'b1);
        measure_latency("latency_after_reset");
        drain();

        fp32_op(32'h40400000, 32'h40000000, 1'b0, 32'h40C00000, 3'b000, "fp32_3x2");
        for (int i = 0; i < 20; i++) begin
            ra = $urandom;
            rb = $urandom;
            ref_mul(64'(ra), 64'(rb), 1'(i & 1), 8, 23, res, fl);
            fp32_op(ra, rb, 1'(i & 1), res[31:0], fl, "fp32_random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
